// File: rtl/ppe_wrr_packet_arbiter.sv
// ppe_wrr_packet_arbiter
// Weighted round-robin arbiter with packet locking for router output ports.
// A requester keeps the grant from its first flit through its tail flit, and it
// may send up to its weight's worth of consecutive packets before priority
// rotates to the next index.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   ce        - clock enable; state updates only when high
//   i_request - request vector, bit k = requester k
//   i_last    - tail-flit flag per requester, qualified by i_request
//   i_weight  - packed weights, field k = i_weight[k*WEIGHT_W +: WEIGHT_W]
//   o_grant   - one-hot or zero grant (combinational from state + inputs)
//   o_locked  - registered; high while a packet owns the output
//   o_owner   - registered index of the current/last owner
module ppe_wrr_packet_arbiter #(
    parameter int unsigned N        = 5,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [N-1:0]          i_request,
    input  logic [N-1:0]          i_last,
    input  logic [N*WEIGHT_W-1:0] i_weight,
    output logic [N-1:0]          o_grant,
    output logic                  o_locked,
    output logic [$clog2(N)-1:0]  o_owner
);

    localparam int unsigned OW = $clog2(N);

    typedef enum logic {
        StArb,
        StLock
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    // Index of the requester that most recently completed a packet; used only
    // to decide whether the weight counter continues or restarts.
    logic [OW-1:0]   last_q, last_d;
    // Top-priority index (the one-hot prio bit, stored as its position).
    logic [OW-1:0]   prio_q, prio_d;
    logic [WEIGHT_W-1:0] used_q, used_d;

    logic            found;
    logic [OW-1:0]   gidx;
    logic [N-1:0]    grant;
    int unsigned     j;

    logic [WEIGHT_W-1:0] wsel;
    logic [WEIGHT_W-1:0] weff;
    logic [WEIGHT_W-1:0] used_base;
    logic [WEIGHT_W:0]   used_inc;

    // Grant selection
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        j     = 0;
        if (state_q == StArb) begin
            // Circular search starting at the priority index.
            for (int unsigned i = 0; i < N; i++) begin
                j = int'(prio_q) + i;
                if (j >= N) begin
                    j = j - N;
                end
                if (!found && i_request[j]) begin
                    found = 1'b1;
                    gidx  = OW'(j);
                end
            end
        end else begin
            // Locked: only the owner may be granted; a dropped request yields zero.
            gidx  = owner_q;
            found = i_request[owner_q];
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign o_grant  = grant;
    assign o_locked = (state_q == StLock);
    assign o_owner  = owner_q;

    // Weight accounting for a completing packet of requester gidx
    always_comb begin
        wsel      = i_weight[int'(gidx)*WEIGHT_W +: WEIGHT_W];
        weff      = (wsel == '0) ? {{(WEIGHT_W-1){1'b0}}, 1'b1} : wsel;
        used_base = (gidx != last_q) ? '0 : used_q;
        used_inc  = {1'b0, used_base} + {{WEIGHT_W{1'b0}}, 1'b1};
    end

    // Next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        prio_d  = prio_q;
        used_d  = used_q;
        if (ce && found) begin
            owner_d = gidx;
            if (i_last[gidx]) begin
                // Packet completes this cycle.
                state_d = StArb;
                last_d  = gidx;
                if (used_inc >= {1'b0, weff}) begin
                    prio_d = (gidx == OW'(N - 1)) ? '0 : gidx + OW'(1);
                    used_d = '0;
                end else begin
                    prio_d = gidx;
                    used_d = used_inc[WEIGHT_W-1:0];
                end
            end else begin
                state_d = StLock;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StArb;
            owner_q <= '0;
            last_q  <= '0;
            prio_q  <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            prio_q  <= prio_d;
            used_q  <= used_d;
        end
    end

endmodule

// File: tb/tb_ppe_wrr_packet_arbiter.sv
module tb_ppe_wrr_packet_arbiter;

    localparam int unsigned N        = 5;
    localparam int unsigned WEIGHT_W = 4;

    logic                  clk;
    logic                  reset;
    logic                  ce;
    logic [N-1:0]          i_request;
    logic [N-1:0]          i_last;
    logic [N*WEIGHT_W-1:0] i_weight;
    logic [N-1:0]          o_grant;
    logic                  o_locked;
    logic [2:0]            o_owner;

    int n_checks = 0;
    int n_errors = 0;

    ppe_wrr_packet_arbiter #(
        .N        (N),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .i_request (i_request),
        .i_last    (i_last),
        .i_weight  (i_weight),
        .o_grant   (o_grant),
        .o_locked  (o_locked),
        .o_owner   (o_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    logic [N-1:0] exp_g;
    int seq2 [8] = '{0, 1, 1, 1, 2, 3, 4, 0};

    initial begin
        reset     = 1'b1;
        ce        = 1'b1;
        i_request = '0;
        i_last    = '0;
        i_weight  = 20'h11111;

        // Reset state
        do_reset();
        i_request = 5'b11111;
        i_last    = 5'b11111;
        #1;
        check("rst_locked", 32'(o_locked), 32'd0);
        check("rst_owner", 32'(o_owner), 32'd0);
        check("rst_grant", 32'(o_grant), 32'b00001);

        // Weights all 1, single-flit: 0,1,2,3,4,0
        for (int c = 0; c < 6; c++) begin
            exp_g = 5'b00001 << (c % 5);
            check($sformatf("rr1_c%0d", c), 32'(o_grant), 32'(exp_g));
            tick();
        end

        // Weight[1]=3: 0,1,1,1,2,3,4,0
        i_weight = 20'h11131;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            exp_g = 5'b00001 << seq2[c];
            check($sformatf("wrr_c%0d", c), 32'(o_grant), 32'(exp_g));
            tick();
        end
        i_weight = 20'h11111;

        // 4-flit packet from req0 while req2 requests single-flit
        do_reset();
        i_request = 5'b00101;
        i_last    = 5'b00100;
        #1;
        check("pkt_c1_grant", 32'(o_grant), 32'b00001);
        check("pkt_c1_locked", 32'(o_locked), 32'd0);
        tick();
        check("pkt_c2_grant", 32'(o_grant), 32'b00001);
        check("pkt_c2_locked", 32'(o_locked), 32'd1);
        check("pkt_c2_owner", 32'(o_owner), 32'd0);
        tick();
        check("pkt_c3_grant", 32'(o_grant), 32'b00001);
        check("pkt_c3_locked", 32'(o_locked), 32'd1);
        tick();
        i_last = 5'b00101;
        #1;
        check("pkt_c4_grant", 32'(o_grant), 32'b00001);
        check("pkt_c4_locked", 32'(o_locked), 32'd1);
        tick();
        check("pkt_c5_grant", 32'(o_grant), 32'b00100);
        check("pkt_c5_locked", 32'(o_locked), 32'd0);

        // Locked owner 3 drops its request mid-packet
        do_reset();
        i_request = 5'b01000;
        i_last    = 5'b00000;
        #1;
        check("drop_first", 32'(o_grant), 32'b01000);
        tick();
        i_request = 5'b11111;
        #1;
        check("drop_lock_grant", 32'(o_grant), 32'b01000);
        check("drop_owner", 32'(o_owner), 32'd3);
        tick();
        i_request = 5'b10111;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("drop_gap%0d_grant", c), 32'(o_grant), 32'd0);
            check($sformatf("drop_gap%0d_locked", c), 32'(o_locked), 32'd1);
            tick();
        end
        i_request = 5'b11111;
        i_last    = 5'b11111;
        #1;
        check("drop_resume", 32'(o_grant), 32'b01000);
        tick();
        check("drop_unlock", 32'(o_locked), 32'd0);
        check("drop_owner_after", 32'(o_owner), 32'd3);
        check("drop_next", 32'(o_grant), 32'b10000);

        // ce=0 freezes state; tails in those cycles do not complete
        do_reset();
        i_request = 5'b00011;
        i_last    = 5'b00011;
        ce        = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("ce0_c%0d", c), 32'(o_grant), 32'b00001);
            tick();
        end
        i_request = 5'b00010;
        #1;
        check("ce0_track", 32'(o_grant), 32'b00010);
        i_request = 5'b00011;
        ce        = 1'b1;
        #1;
        check("ce1_grant", 32'(o_grant), 32'b00001);
        tick();
        check("ce1_rotate", 32'(o_grant), 32'b00010);

        // Reset asserted during LOCK(2)
        do_reset();
        i_request = 5'b00100;
        i_last    = 5'b00000;
        tick();
        check("rstlk_locked", 32'(o_locked), 32'd1);
        check("rstlk_owner", 32'(o_owner), 32'd2);
        i_request = 5'b10100;
        i_last    = 5'b10100;
        reset     = 1'b1;
        #1;
        check("rstlk_async", 32'(o_locked), 32'd0);
        reset = 1'b0;
        #1;
        check("rstlk_first", 32'(o_grant), 32'b00100);
        tick();
        check("rstlk_second", 32'(o_grant), 32'b10000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
